// File: rtl/posit_pkg.sv
// Shared posit-unit types: decoder FSM states, the NaR bit pattern and a decoded-operand record.
package posit_pkg;

  typedef enum logic [2:0] {IDLE, ABS, SCAN, ALIGN, DONE} dec_state_t;

  localparam int P_N  = 32;
  localparam int P_ES = 2;
  localparam int P_RS = $clog2(P_N);

  // NaR is a lone sign bit; returned in a wide word so any N up to 64 can cast it down
  function automatic logic [63:0] NAR(input int n);
    return 64'd1 << (n - 1);
  endfunction

  typedef struct packed {
    logic                  sign;
    logic signed [P_RS:0]  k;
    logic [P_ES-1:0]       exp;
    logic [P_N-1:0]        mant;
    logic                  zero;
    logic                  inf;
  } dec_posit_t;

endpackage

// File: rtl/posit_decoder_seq_if.sv
// Operand-in / fields-out handshake bundle of the sequential posit decoder.
interface posit_decoder_seq_if #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
);
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        in_posit;
  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic signed [RS:0]  out_k;
  logic [ES-1:0]       out_exp;
  logic [N-1:0]        out_mant;
  logic                out_zero;
  logic                out_inf;

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_k, out_exp, out_mant, out_zero, out_inf
  );

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_k, out_exp, out_mant, out_zero, out_inf
  );
endinterface

// File: rtl/posit_regime_scanner.sv
// Serial regime-run scanner: loads a sign-stripped magnitude and counts the regime run one bit per cycle.
module posit_regime_scanner #(
  parameter int N  = 32,
  parameter int RS = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [N-1:0]  i_word,
  output logic          o_done,
  output logic [RS-1:0] o_run,
  output logic          o_first,
  output logic [N-1:0]  o_shifter
);
  localparam logic [RS-1:0] RUN_MAX = RS'(N - 1);

  logic          r_active;
  logic [N-1:0]  r_sh;
  logic [RS-1:0] r_run;
  logic          r_first;
  logic          w_cont;

  // A run stops on the first opposite bit or when it has consumed the whole word
  assign w_cont = r_active && (r_sh[N-1] == r_first) && (r_run < RUN_MAX);
  assign o_done = r_active && !w_cont;

  always_ff @(posedge clk) begin
    if (rst)
      r_active <= 1'b0;
    else if (i_start)
      r_active <= 1'b1;
    else if (o_done)
      r_active <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_sh    <= i_word << 1;
      r_first <= i_word[N-1];
      r_run   <= RS'(1);
    end else if (w_cont) begin
      r_sh    <= r_sh << 1;
      r_run   <= r_run + RS'(1);
    end
  end

  assign o_run     = r_run;
  assign o_first   = r_first;
  assign o_shifter = r_sh;
endmodule

// File: rtl/posit_decoder_seq.sv
// Multi-cycle posit unpacker: sign, regime k, exponent and hidden-bit mantissa behind valid/ready.
module posit_decoder_seq
  import posit_pkg::*;
#(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) (
  input logic               clk,
  input logic               rst,
  posit_decoder_seq_if.slave bus
);
  localparam logic [N-1:0]  NAR_W   = N'(NAR(N));
  localparam logic [RS-1:0] RUN_MAX = RS'(N - 1);

  dec_state_t          r_state, w_next;
  logic [N-1:0]        r_word;
  logic                r_sign, r_zero, r_inf;
  logic signed [RS:0]  r_k;
  logic [ES-1:0]       r_exp;
  logic [N-1:0]        r_mant;

  logic                w_accept, w_in_zero, w_in_nar;
  logic [N-1:0]        w_mag;
  logic                w_done, w_first;
  logic [RS-1:0]       w_run;
  logic [N-1:0]        w_shift, w_rem;
  logic [N-2:0]        w_frac;

  function automatic logic signed [RS:0] calc_k(input logic first, input logic [RS-1:0] run);
    logic signed [RS:0] v;
    v = signed'({1'b0, run});
    return first ? v - (RS+1)'(1) : -v;
  endfunction

  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_in_zero = (bus.in_posit == '0);
  assign w_in_nar  = (bus.in_posit == NAR_W);
  assign w_mag     = r_sign ? -r_word : r_word;

  posit_regime_scanner #(.N(N), .RS(RS)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .i_start   (r_state == ABS),
    .i_word    (w_mag << 1),
    .o_done    (w_done),
    .o_run     (w_run),
    .o_first   (w_first),
    .o_shifter (w_shift)
  );

  // A saturated run leaves no terminator to drop
  assign w_rem  = (w_run < RUN_MAX) ? (w_shift << 1) : w_shift;
  assign w_frac = w_rem[N-2:0] << (ES - 1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_in_zero || w_in_nar) ? DONE : ABS;
      ABS:     w_next = SCAN;
      SCAN:    if (w_done) w_next = ALIGN;
      ALIGN:   w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign <= 1'b0;
      r_zero <= 1'b0;
      r_inf  <= 1'b0;
      r_k    <= '0;
      r_exp  <= '0;
      r_mant <= '0;
    end else if (w_accept) begin
      r_word <= bus.in_posit;
      r_sign <= bus.in_posit[N-1];
      r_zero <= w_in_zero;
      r_inf  <= w_in_nar;
      r_k    <= '0;
      r_exp  <= '0;
      r_mant <= '0;
    end else if (r_state == ALIGN) begin
      r_k    <= calc_k(w_first, w_run);
      r_exp  <= w_rem[N-1 -: ES];
      r_mant <= {1'b1, w_frac};
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_sign  = r_sign;
  assign bus.out_k     = r_k;
  assign bus.out_exp   = r_exp;
  assign bus.out_mant  = r_mant;
  assign bus.out_zero  = r_zero;
  assign bus.out_inf   = r_inf;
endmodule

// File: tb/tb_posit_decoder_seq.sv
// Bench for posit_decoder_seq (N=32, ES=2): directed and random operands against a field-level posit model.
module tb_posit_decoder_seq;
  import posit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit_decoder_seq_if #(.N(32), .ES(2)) bus ();

  posit_decoder_seq #(.N(32), .ES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    dec_posit_t d;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   force_low = 1'b0;

  function automatic void chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // Posit reading: strip sign by 2's complement, regime = run of identical leading bits,
  // then ES exponent bits, then the fraction; lat counts cycles from accept to visible valid.
  function automatic dec_posit_t model(input logic [31:0] w, output int lat);
    dec_posit_t   r;
    logic [31:0]  mag;
    logic [30:0]  rest, x;
    logic [63:0]  v;
    int           run;
    logic         first;
    r = '0;
    r.sign = w[31];
    if (w == 32'h0) begin
      r.zero = 1'b1; lat = 1;
    end else if (w == 32'h8000_0000) begin
      r.inf = 1'b1; lat = 1;
    end else begin
      mag   = w[31] ? (~w + 32'd1) : w;
      rest  = mag[30:0];
      first = rest[30];
      x     = first ? ~rest : rest;
      run   = 0;
      while (run < 31 && x[30-run] == 1'b0) run++;
      lat   = 3 + run;
      r.k   = first ? 6'(run - 1) : 6'(-run);
      v     = {rest, 33'b0} << (run + 1);
      r.exp  = v[63:62];
      r.mant = {1'b1, v[61:31]};
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    int   lt;
    bit   due;
    if (rst) begin
      q.delete();
    end else begin
      chk(bus.in_ready == (q.size() == 0), "in_ready", 64'(bus.in_ready), 64'(q.size() == 0));
      if (q.size() != 0) begin
        e   = q[0];
        due = (cyc - e.acc) >= (e.lat - 1);
        chk(bus.out_valid == due, "out_valid_timing", 64'(bus.out_valid), 64'(due));
        if (bus.out_valid) begin
          chk(bus.out_sign == e.d.sign, "sign", 64'(bus.out_sign), 64'(e.d.sign));
          chk(bus.out_k    == e.d.k,    "k",    64'(bus.out_k),    64'(e.d.k));
          chk(bus.out_exp  == e.d.exp,  "exp",  64'(bus.out_exp),  64'(e.d.exp));
          chk(bus.out_mant == e.d.mant, "mant", 64'(bus.out_mant), 64'(e.d.mant));
          chk(bus.out_zero == e.d.zero, "zero", 64'(bus.out_zero), 64'(e.d.zero));
          chk(bus.out_inf  == e.d.inf,  "inf",  64'(bus.out_inf),  64'(e.d.inf));
          if (bus.out_ready) void'(q.pop_front());
        end
      end else begin
        chk(bus.out_valid == 1'b0, "idle_valid", 64'(bus.out_valid), 64'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
        e.d   = model(bus.in_posit, lt);
        e.lat = lt;
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  initial begin : rdy
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_posit = w;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) chk(1'b0, "send_timeout", 64'(w), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_posit = $urandom;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk(1'b0, "drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input logic [31:0] w, input logic s, input int k, input logic [1:0] ex,
                     input logic [31:0] m, input logic z, input logic nr, input int lat_exp);
    dec_posit_t d;
    int lt;
    d = model(w, lt);
    chk(d.sign == s && d.k == 6'(k) && d.exp == ex && d.mant == m && d.zero == z && d.inf == nr,
        "model_fields", 64'(d), {s, 6'(k), ex, m, z, nr});
    chk(lt == lat_exp, "model_latency", 64'(lt), 64'(lat_exp));
  endtask

  initial begin : drv
    logic [31:0] w;
    bus.in_valid = 1'b0;
    bus.in_posit = '0;

    pin(32'h4000_0000, 1'b0,   0, 2'd0, 32'h8000_0000, 1'b0, 1'b0, 4);
    pin(32'h4400_0000, 1'b0,   0, 2'd0, 32'hC000_0000, 1'b0, 1'b0, 4);
    pin(32'h4800_0000, 1'b0,   0, 2'd1, 32'h8000_0000, 1'b0, 1'b0, 4);
    pin(32'hC000_0000, 1'b1,   0, 2'd0, 32'h8000_0000, 1'b0, 1'b0, 4);
    pin(32'h7FFF_FFFF, 1'b0,  30, 2'd0, 32'h8000_0000, 1'b0, 1'b0, 34);
    pin(32'h0000_0001, 1'b0, -30, 2'd0, 32'h8000_0000, 1'b0, 1'b0, 33);
    pin(32'h0000_0000, 1'b0,   0, 2'd0, 32'h0,         1'b1, 1'b0, 1);
    pin(32'h8000_0000, 1'b1,   0, 2'd0, 32'h0,         1'b0, 1'b1, 1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk(bus.in_ready == 1'b1 && bus.out_valid == 1'b0, "reset_handshake",
        64'({bus.in_ready, bus.out_valid}), 64'b10);
    chk({bus.out_sign, bus.out_k, bus.out_exp, bus.out_mant, bus.out_zero, bus.out_inf} == '0,
        "reset_fields", 64'({bus.out_k, bus.out_exp, bus.out_mant}), 64'd0);
    @(posedge clk);
    #1;

    send(32'h4000_0000);
    send(32'h4400_0000);
    send(32'h4800_0000);
    send(32'hC000_0000);
    send(32'h7FFF_FFFF);
    send(32'h0000_0001);
    send(32'h0000_0000);
    send(32'h8000_0000);
    drain();

    force_low = 1'b1;
    send(32'h4800_0000);
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    repeat (5) @(posedge clk);
    #1;
    force_low = 1'b0;
    drain();

    send(32'h0000_0001);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk(bus.out_valid == 1'b0 && bus.in_ready == 1'b1, "reset_in_scan",
        64'({bus.out_valid, bus.in_ready}), 64'b01);
    @(posedge clk);
    #1;
    send(32'h4400_0000);
    drain();

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0:       w = $urandom;
        1:       w = $urandom >> $urandom_range(1, 31);
        2:       w = ~($urandom >> $urandom_range(1, 31));
        3:       w = {1'b0, 31'h7FFF_FFFF} >> $urandom_range(0, 30);
        default: w = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h8000_0000;
      endcase
      send(w);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
